// File: rtl/button_event_pkg.sv
// Shared definitions for the button event scheduler.
// Holds:
//   - event codes carried on the event stream
//   - the per-button FSM state encoding
//   - the event record stored in the event FIFO
//   - a clog2 helper that never returns less than 1
package button_event_pkg;

    localparam logic [1:0] EV_SHORT  = 2'd0;
    localparam logic [1:0] EV_LONG   = 2'd1;
    localparam logic [1:0] EV_REPEAT = 2'd2;

    // Widest button index supported (up to 16 buttons).
    localparam int ID_MAX_W = 4;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESS    = 2'd2,
        HELD     = 2'd3
    } btn_state_t;

    typedef struct packed {
        logic [1:0]          code;
        logic [ID_MAX_W-1:0] id;
    } ev_rec_t;

    // Returns the number of bits needed to hold values 0..value-1, minimum 1.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/button_event_fsm.sv
// Per-button press classifier.
// Tracks how long one debounced level has been high and raises SHORT, LONG
// and REPEAT events into a one-deep pending slot that the arbiter drains.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   enable      - 0 forces the FSM back to WAIT_LOW (pending slot is kept)
//   level       - debounced button level, 1 = pressed
//   grant       - arbiter takes the pending event this cycle
//   pending     - an event is waiting for the arbiter
//   pend_code   - code of the waiting event
//   drop        - a new event was lost because the slot was still occupied
//   active      - FSM is in PRESS or HELD
module button_event_fsm
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       level,
    input  logic       grant,
    output logic       pending,
    output logic [1:0] pend_code,
    output logic       drop,
    output logic       active
);

    localparam int CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX + 1);

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             emit_nxt;
    logic [1:0]       code_nxt;

    logic             vld_p0;
    logic [1:0]       code_p0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + CNT_W'(1);
        emit_nxt  = 1'b0;
        code_nxt  = EV_SHORT;
        if (!enable) begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = '0;
        end else begin
            case (state)
                WAIT_LOW: begin
                    // A level held through reset or disable must be released
                    // before it can start a new press.
                    if (!level) begin
                        state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    if (level) begin
                        state_nxt = PRESS;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (level) begin
                        if (cnt_inc == CNT_W'(LONG_CYCLES)) begin
                            emit_nxt  = 1'b1;
                            code_nxt  = EV_LONG;
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        emit_nxt  = 1'b1;
                        code_nxt  = EV_SHORT;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (level) begin
                        if (cnt_inc == CNT_W'(REPEAT_CYCLES)) begin
                            emit_nxt = 1'b1;
                            code_nxt = EV_REPEAT;
                            cnt_nxt  = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stage p0: event detected on the triggering sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WAIT_LOW;
            cnt    <= '0;
            vld_p0 <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            vld_p0 <= emit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        code_p0 <= code_nxt;
    end

    // Stage p1: pending slot presented to the arbiter. A slot being granted
    // this cycle is free to take the new event.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (vld_p0 && (!pending || grant)) begin
            pending <= 1'b1;
        end else if (grant) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0 && (!pending || grant)) begin
            pend_code <= code_p0;
        end
    end

    assign drop   = vld_p0 && pending && !grant;
    assign active = (state == PRESS) || (state == HELD);

endmodule

// File: rtl/button_event_scheduler.sv
// Button event scheduler top.
// Classifies N debounced buttons into SHORT/LONG/REPEAT events, merges them
// with a round-robin arbiter and delivers them through a show-ahead FIFO.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   enable      - 1 = detection running; 0 = FSMs parked, FIFO still drains
//   btn_level   - debounced levels, 1 = pressed
//   ev_valid    - FIFO head valid
//   ev_ready    - consumer takes head when ev_valid & ev_ready
//   ev_code     - head event code (0 SHORT, 1 LONG, 2 REPEAT)
//   ev_id       - head button index
//   overflow    - sticky, an event was dropped
//   ovf_clear   - clears overflow (a new drop in the same cycle wins)
//   busy        - a button is mid-press or the FIFO holds events
module button_event_scheduler
    import button_event_pkg::*;
#(
    parameter int N_BUTTONS     = 4,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 12500000,
    parameter int FIFO_DEPTH    = 4,
    localparam int ID_W         = clog2_min1(N_BUTTONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_BUTTONS-1:0] btn_level,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [1:0]           ev_code,
    output logic [ID_W-1:0]      ev_id,
    output logic                 overflow,
    input  logic                 ovf_clear,
    output logic                 busy
);

    localparam int AW = clog2_min1(FIFO_DEPTH);

    logic [N_BUTTONS-1:0] pending;
    logic [1:0]           pend_code [N_BUTTONS];
    logic [N_BUTTONS-1:0] drop;
    logic [N_BUTTONS-1:0] active;
    logic [N_BUTTONS-1:0] grant_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
            button_event_fsm #(
                .LONG_CYCLES   (LONG_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_fsm (
                .clk       (clk),
                .rst       (rst),
                .enable    (enable),
                .level     (btn_level[gi]),
                .grant     (grant_vec[gi]),
                .pending   (pending[gi]),
                .pend_code (pend_code[gi]),
                .drop      (drop[gi]),
                .active    (active[gi])
            );
        end
    endgenerate

    // FIFO state
    ev_rec_t        mem [FIFO_DEPTH];
    ev_rec_t        last_q;
    ev_rec_t        head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, push, pop, can_push;

    // Arbiter state: rr_ptr is the first index searched next cycle.
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic [1:0]      grant_code;

    assign ev_valid = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    // A pop on the same edge frees a slot for the grant.
    assign can_push = !full || pop;

    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        idx        = 0;
        sel        = '0;
        grant_vec  = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant_code = EV_SHORT;
        if (can_push) begin
            for (int k = 0; k < N_BUTTONS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_BUTTONS) begin
                    idx = idx - N_BUTTONS;
                end
                sel = ID_W'(idx);
                if (!grant_any && pending[sel]) begin
                    grant_any  = 1'b1;
                    grant_idx  = sel;
                    grant_code = pend_code[sel];
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign push = grant_any;

    // Stage p2: granted event written into the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{code: grant_code, id: ID_MAX_W'(grant_idx)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= (grant_idx == ID_W'(N_BUTTONS - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (|drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // While empty the outputs hold the last event that left the FIFO.
    assign head    = ev_valid ? mem[rd_ptr] : last_q;
    assign ev_code = head.code;
    assign ev_id   = head.id[ID_W-1:0];

    logic unused_id_bits;
    assign unused_id_bits = ^head.id;

    assign busy = (|active) || ev_valid;

endmodule

// File: tb/tb_button_event_scheduler.sv
module tb_button_event_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] btn_level = 4'b0000;
    logic       ev_ready = 1'b1;
    logic       ovf_clear = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic [1:0] ev_id;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q [$];
    logic [3:0] exp_head;

    localparam logic [1:0] S = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] R = 2'd2;

    button_event_scheduler #(
        .N_BUTTONS     (N),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .btn_level (btn_level),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_id     (ev_id),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [1:0] code, input logic [1:0] id);
        exp_q.push_back({code, id});
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int settle);
        btn_level = mask;
        tick(hold);
        btn_level = 4'b0000;
        tick(settle);
    endtask

    task automatic drained(input string name);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=code%0d/id%0d required=none", ev_code, ev_id);
            end else begin
                exp_head = exp_q.pop_front();
                check("event_code_id", {ev_code, ev_id}, exp_head);
            end
        end
    end

    initial begin
        // Reset with btn0 held through it
        rst = 1'b1;
        btn_level = 4'b0001;
        tick(3);
        check("reset_valid", ev_valid, 0);
        check("reset_code", ev_code, 0);
        check("reset_id", ev_id, 0);
        check("reset_ovf", overflow, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        tick(10);
        check("wait_low_busy", busy, 0);
        drained("wait_low_no_event");

        // Release, then a 5-sample press gives one SHORT two edges after release
        btn_level = 4'b0000;
        tick(1);
        btn_level = 4'b0001;
        tick(5);
        expect_ev(S, 2'd0);
        btn_level = 4'b0000;
        tick(1);
        check("short_lat_e1", ev_valid, 0);
        tick(1);
        check("short_lat_e2", ev_valid, 0);
        tick(1);
        check("short_lat_rise", ev_valid, 1);
        tick(4);
        drained("short_drain");

        // Long hold: LONG at 20, REPEAT at 28 and 36, nothing on release
        expect_ev(L, 2'd1);
        expect_ev(R, 2'd1);
        expect_ev(R, 2'd1);
        btn_level = 4'b0010;
        tick(21);
        check("long_lat_before", ev_valid, 0);
        check("hold_busy", busy, 1);
        tick(1);
        check("long_lat_rise", ev_valid, 1);
        check("long_code", ev_code, 1);
        tick(18);
        btn_level = 4'b0000;
        tick(12);
        drained("long_repeat_drain");

        // Boundary: 19 samples -> SHORT, 20 samples -> LONG only
        expect_ev(S, 2'd2);
        press(4'b0100, 19, 6);
        expect_ev(L, 2'd2);
        press(4'b0100, 20, 10);
        drained("boundary_drain");

        // Round robin: make last grant 3, then 0,2,3 on consecutive cycles
        expect_ev(S, 2'd3);
        press(4'b1000, 1, 6);
        expect_ev(S, 2'd0);
        expect_ev(S, 2'd2);
        expect_ev(S, 2'd3);
        btn_level = 4'b1101;
        tick(3);
        btn_level = 4'b0000;
        tick(3);
        check("rr_first_id", ev_id, 0);
        tick(1);
        check("rr_second_id", ev_id, 2);
        tick(1);
        check("rr_third_id", ev_id, 3);
        tick(4);
        drained("rr_a_drain");
        // Last grant 2 -> order 3,0,2
        expect_ev(S, 2'd2);
        press(4'b0100, 1, 6);
        expect_ev(S, 2'd3);
        expect_ev(S, 2'd0);
        expect_ev(S, 2'd2);
        press(4'b1101, 3, 8);
        drained("rr_b_drain");

        // Backpressure: fill FIFO, two pending, then a drop
        ev_ready = 1'b0;
        press(4'b1111, 2, 8);
        check("full_head_valid", ev_valid, 1);
        check("full_head_id", ev_id, 3);
        check("full_busy", busy, 1);
        press(4'b0011, 2, 6);
        check("ovf_before_drop", overflow, 0);
        press(4'b0001, 2, 6);
        check("ovf_after_drop", overflow, 1);
        expect_ev(S, 2'd3);
        expect_ev(S, 2'd0);
        expect_ev(S, 2'd1);
        expect_ev(S, 2'd2);
        expect_ev(S, 2'd0);
        expect_ev(S, 2'd1);
        ev_ready = 1'b1;
        tick(12);
        drained("backpressure_drain");
        check("ovf_sticky", overflow, 1);
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Reset with 3 queued events and btn3 mid-hold
        ev_ready = 1'b0;
        btn_level = 4'b1111;
        tick(2);
        btn_level = 4'b1000;
        tick(6);
        check("pre_rst_valid", ev_valid, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_busy", busy, 0);
        ev_ready = 1'b1;
        tick(3);
        btn_level = 4'b0000;
        tick(20);
        drained("mid_rst_no_event");

        // Disable during PRESS: no SHORT, queued event still drains
        ev_ready = 1'b0;
        expect_ev(S, 2'd0);
        press(4'b0001, 2, 6);
        btn_level = 4'b0010;
        tick(3);
        enable = 1'b0;
        tick(1);
        check("disable_keeps_fifo", ev_valid, 1);
        ev_ready = 1'b1;
        tick(4);
        btn_level = 4'b0000;
        tick(4);
        enable = 1'b1;
        tick(20);
        drained("disable_drain");
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
